// File: rtl/rst_seq_gen.sv
// ============================================================================
// Module   : rst_seq_gen
// Purpose  : Power-on reset/enable sequencer. It holds NUM_CH reset lines, then
//            releases them one channel at a time in bit order.
// Revision : 1.0 - initial parametrised release
// ============================================================================
`default_nettype none

module rst_seq_gen #(
  parameter int CNT_W        = 32,
  parameter int DELAY_CYCLES = 10,
  parameter int STAGE_GAP    = 4,
  parameter int NUM_CH       = 4
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              restart,
  input  logic              hold,
  output logic [NUM_CH-1:0] rst_out,
  output logic [NUM_CH-1:0] en_out,
  output logic              done,
  output logic              busy
);

  generate
    if ((DELAY_CYCLES < 1) || (STAGE_GAP < 1) || (NUM_CH < 1) || (NUM_CH > 32) ||
        (CNT_W < 1) || ((longint'(DELAY_CYCLES) >> CNT_W) != 0) ||
        ((longint'(STAGE_GAP) >> CNT_W) != 0)) begin : g_bad_params
      $fatal(1, "rst_seq_gen: invalid parameter set");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_HOLD  = 2'd0,
    ST_STAGE = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(DELAY_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(STAGE_GAP - 1);
  localparam logic [5:0]       LAST_CH    = 6'(NUM_CH - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [5:0]        ch_idx_q, ch_idx_d;
  logic [NUM_CH-1:0] rst_out_q, rst_out_d;
  logic [NUM_CH-1:0] en_out_q, en_out_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;
  logic [NUM_CH-1:0] release_mask;

  // One-hot mask of the channel addressed by ch_idx (channel 0 while in HOLD).
  always_comb begin
    release_mask = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_idx_q == 6'(i)) begin
        release_mask[i] = 1'b1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ch_idx_d  = ch_idx_q;
    rst_out_d = rst_out_q;
    done_d    = done_q;
    busy_d    = busy_q;

    case (state_q)
      ST_HOLD: begin
        if (!hold) begin
          if (cnt_q == DELAY_LAST) begin
            rst_out_d = rst_out_q & ~release_mask;
            cnt_d     = '0;
            ch_idx_d  = 6'd1;
            if (NUM_CH == 1) begin
              state_d = ST_RUN;
              done_d  = 1'b1;
              busy_d  = 1'b0;
            end else begin
              state_d = ST_STAGE;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_STAGE: begin
        if (!hold) begin
          if (cnt_q == GAP_LAST) begin
            rst_out_d = rst_out_q & ~release_mask;
            cnt_d     = '0;
            if (ch_idx_q == LAST_CH) begin
              state_d = ST_RUN;
              done_d  = 1'b1;
              busy_d  = 1'b0;
            end else begin
              ch_idx_d = ch_idx_q + 6'd1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_RUN: begin
        rst_out_d = '0;
        done_d    = 1'b1;
        busy_d    = 1'b0;
      end
      default: begin
        state_d   = ST_HOLD;
        cnt_d     = '0;
        ch_idx_d  = '0;
        rst_out_d = '1;
        done_d    = 1'b0;
        busy_d    = 1'b1;
      end
    endcase

    // Soft restart overrides everything, including hold.
    if (restart) begin
      state_d   = ST_HOLD;
      cnt_d     = '0;
      ch_idx_d  = '0;
      rst_out_d = '1;
      done_d    = 1'b0;
      busy_d    = 1'b1;
    end

    en_out_d = ~rst_out_d;
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q   <= ST_HOLD;
      cnt_q     <= '0;
      ch_idx_q  <= '0;
      rst_out_q <= '1;
      en_out_q  <= '0;
      done_q    <= 1'b0;
      busy_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ch_idx_q  <= ch_idx_d;
      rst_out_q <= rst_out_d;
      en_out_q  <= en_out_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
    end
  end

  assign rst_out = rst_out_q;
  assign en_out  = en_out_q;
  assign done    = done_q;
  assign busy    = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_rst_seq_gen.sv
// ============================================================================
// Module   : tb_rst_seq_gen
// Purpose  : Directed bench for rst_seq_gen (default, single-channel, 32-channel).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rst_seq_gen;

  logic        sys_clk;
  logic        sys_rst;
  logic        restart;
  logic        hold;

  logic [3:0]  rst_out_m, en_out_m;
  logic        done_m, busy_m;
  logic [0:0]  rst_out_a, en_out_a;
  logic        done_a, busy_a;
  logic [31:0] rst_out_b, en_out_b;
  logic        done_b, busy_b;

  int checks;
  int failures;
  int e;
  int e_base;
  int rel [4];

  rst_seq_gen #(.CNT_W(32), .DELAY_CYCLES(10), .STAGE_GAP(4), .NUM_CH(4)) dut_m (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .restart(restart), .hold(hold),
    .rst_out(rst_out_m), .en_out(en_out_m), .done(done_m), .busy(busy_m)
  );

  rst_seq_gen #(.CNT_W(8), .DELAY_CYCLES(1), .STAGE_GAP(1), .NUM_CH(1)) dut_a (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .restart(restart), .hold(hold),
    .rst_out(rst_out_a), .en_out(en_out_a), .done(done_a), .busy(busy_a)
  );

  rst_seq_gen #(.CNT_W(16), .DELAY_CYCLES(3), .STAGE_GAP(1), .NUM_CH(32)) dut_b (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .restart(restart), .hold(hold),
    .rst_out(rst_out_b), .en_out(en_out_b), .done(done_b), .busy(busy_b)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s at edge %0d: observed=%0h expected=%0h", tag, e, obs, exp);
    end
  endtask

  // Drive inputs for one edge, advance past it, then check the 4-channel DUT
  // against the release offsets held in rel[] relative to the last reset edge.
  task automatic step(input bit rs, input bit rsr, input bit hd);
    logic [3:0] exp_rst;
    logic       exp_done;
    sys_rst = rs;
    restart = rsr;
    hold    = hd;
    @(posedge sys_clk);
    #1;
    e++;
    if (rs || rsr) e_base = e;
    for (int k = 0; k < 4; k++) exp_rst[k] = (e < e_base + rel[k]);
    exp_done = (e >= e_base + rel[3]);
    chk("rst_out", {28'd0, rst_out_m}, {28'd0, exp_rst});
    chk("en_out", {28'd0, en_out_m}, {28'd0, ~exp_rst});
    chk("done", {31'd0, done_m}, {31'd0, exp_done});
    chk("busy", {31'd0, busy_m}, {31'd0, ~exp_done});
  endtask

  task automatic set_rel(input int r0, input int r1, input int r2, input int r3);
    rel[0] = r0; rel[1] = r1; rel[2] = r2; rel[3] = r3;
  endtask

  initial begin
    logic [31:0] exp_b;
    int          released;
    checks   = 0;
    failures = 0;
    e        = -1;
    e_base   = 0;
    sys_rst  = 1'b1;
    restart  = 1'b0;
    hold     = 1'b0;

    // Defaults: reset edge 0, releases at 10/14/18/22, then restart pulse at 30.
    set_rel(10, 14, 18, 22);
    step(1, 0, 0);
    repeat (29) step(0, 0, 0);
    step(0, 1, 0);
    repeat (24) step(0, 0, 0);

    // hold over relative edges 5..7 while in HOLD: every release shifts by 3.
    set_rel(13, 17, 21, 25);
    step(1, 0, 0);
    repeat (4) step(0, 0, 0);
    repeat (3) step(0, 0, 1);
    repeat (20) step(0, 0, 0);

    // hold over relative edges 12..13 while in STAGE: channel 0 unaffected.
    set_rel(10, 16, 20, 24);
    step(1, 0, 0);
    repeat (11) step(0, 0, 0);
    repeat (2) step(0, 0, 1);
    repeat (12) step(0, 0, 0);

    // sys_rst mid-STAGE at relative 16, then sys_rst+restart together.
    set_rel(10, 14, 18, 22);
    step(1, 0, 0);
    repeat (15) step(0, 0, 0);
    step(1, 0, 0);
    repeat (12) step(0, 0, 0);
    repeat (3) step(0, 0, 0);
    step(1, 1, 0);
    repeat (23) step(0, 0, 0);

    // restart and hold together at relative 12: restart wins.
    step(1, 0, 0);
    repeat (11) step(0, 0, 0);
    step(0, 1, 1);
    repeat (23) step(0, 0, 0);

    // restart held high for relative edges 12..15.
    step(1, 0, 0);
    repeat (11) step(0, 0, 0);
    repeat (4) step(0, 1, 0);
    repeat (23) step(0, 0, 0);

    // Single-channel, unit delay/gap: release and done one edge after reset.
    step(1, 0, 0);
    chk("a_rst_at_E", {31'd0, rst_out_a}, 32'd1);
    chk("a_done_at_E", {31'd0, done_a}, 32'd0);
    chk("a_busy_at_E", {31'd0, busy_a}, 32'd1);
    chk("b_rst_at_E", rst_out_b, 32'hFFFF_FFFF);
    for (int j = 1; j <= 36; j++) begin
      step(0, 0, 0);
      if (j == 1) begin
        chk("a_rst_E+1", {31'd0, rst_out_a}, 32'd0);
        chk("a_en_E+1", {31'd0, en_out_a}, 32'd1);
        chk("a_done_E+1", {31'd0, done_a}, 32'd1);
        chk("a_busy_E+1", {31'd0, busy_a}, 32'd0);
      end
      // 32 channels, delay 3, gap 1: channel k falls at E+3+k.
      released = (j < 3) ? 0 : ((j - 2 > 32) ? 32 : j - 2);
      exp_b = (released >= 32) ? 32'd0 : (32'hFFFF_FFFF << released);
      chk("b_rst_out", rst_out_b, exp_b);
      chk("b_en_out", en_out_b, ~exp_b);
      chk("b_done", {31'd0, done_b}, {31'd0, released == 32});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
